full_adder_4bit: RTL and testbench
==================================

FULL_ADDER_4BIT -- requirements
Module: full_adder_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; values 1..32 SHALL be supported.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  qualifies a, b and c_in in the current cycle.
REQ-005 Port: a  input  WIDTH  unsigned addend A.
REQ-006 Port: b  input  WIDTH  unsigned addend B.
REQ-007 Port: c_in  input  1  carry into bit 0.
REQ-008 Port: out_valid  output  1  sum, c_out and total are valid.
REQ-009 Port: sum  output  WIDTH  low WIDTH bits of a+b+c_in.
REQ-010 Port: c_out  output  1  carry out of bit WIDTH-1.
REQ-011 Port: total  output  WIDTH+1  debug concatenation {c_out, sum}.

Function
REQ-012 The block SHALL compute {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1); the result never truncates.
REQ-013 The adder SHALL be a ripple-carry chain of WIDTH full-adder cells; cell i takes a[i], b[i] and the carry from cell i-1, and cell 0 takes c_in.
REQ-014 Each full-adder cell SHALL produce sum = a^b^cin and cout = (a&b)|(cin&(a^b)).
REQ-015 Latency SHALL be exactly 1 cycle: operands sampled with in_valid=1 at edge N SHALL appear on sum/c_out/total with out_valid=1 after edge N.
REQ-016 out_valid SHALL equal in_valid registered by one cycle; there is no backpressure and no ready signal.
REQ-017 When in_valid=0 at an edge, sum, c_out and total SHALL hold their previous values and out_valid SHALL go 0.
REQ-018 Back-to-back in_valid=1 cycles SHALL give a new result every cycle at full throughput.
REQ-019 total SHALL always equal {c_out, sum} and be driven combinationally from the output registers.
REQ-020 Inputs with in_valid=0 SHALL be ignored and SHALL never affect the outputs.

Reset
REQ-021 While rst=1 at a rising edge, out_valid, sum, c_out and total SHALL all be cleared to 0 after that edge.
REQ-022 rst SHALL take priority over in_valid; operands presented in the same cycle as rst SHALL be discarded.
REQ-023 The first valid result after reset SHALL come from the first in_valid=1 cycle with rst=0.

Structure
REQ-024 Shared package adder_pkg SHALL hold the constant ADDER_WIDTH_DEFAULT = 4.
REQ-025 Sub-module full_adder_cell SHALL implement one bit (a, b, cin -> sum, cout), built from two half-adder stages plus an OR gate, with no clock.
REQ-026 full_adder_4bit SHALL instantiate WIDTH full_adder_cell instances in a generate loop, followed by one output register stage.

Verification
REQ-027 After reset, with in_valid=0: out_valid=0, sum=0, c_out=0 and total=0.
REQ-028 a=15, b=15, c_in=1, in_valid=1 -> next cycle sum=15, c_out=1, total=31, out_valid=1.
REQ-029 a=7, b=8, c_in=1 -> sum=0, c_out=1, total=16; then a=0, b=0, c_in=0 -> total=0.
REQ-030 Exhaustive test: all 16x16x2 combinations of a, b and c_in, applied back-to-back -> each cycle total equals a+b+c_in from the previous cycle.
REQ-031 in_valid pulsed 1,0,0 with a=3, b=4, c_in=0 -> total=7 is held for 3 cycles while out_valid goes 1,0,0.
REQ-032 rst asserted in the same cycle as in_valid=1 with a=9, b=9 -> next cycle out_valid=0 and total=0.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared constants for the ripple-carry adder block.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Operand width used when the top level is not overridden.
    localparam int ADDER_WIDTH_DEFAULT = 4;

    // Widest operand the block is intended to support.
    localparam int ADDER_WIDTH_MAX = 32;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : One-bit full adder built from two half-adder stages and an
//                OR gate that merges their carries. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_ha0_sum;
    logic w_ha0_carry;
    logic w_ha1_sum;
    logic w_ha1_carry;

    // First half adder combines the two operand bits.
    assign w_ha0_sum   = a ^ b;
    assign w_ha0_carry = a & b;

    // Second half adder folds in the incoming carry.
    assign w_ha1_sum   = w_ha0_sum ^ cin;
    assign w_ha1_carry = w_ha0_sum & cin;

    // Only one half adder can generate a carry at a time, so OR merges them.
    assign sum  = w_ha1_sum;
    assign cout = w_ha0_carry | w_ha1_carry;

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/full_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_4bit
//  Description : WIDTH-bit ripple-carry adder with a single registered output
//                stage. Produces {c_out, sum} = a + b + c_in one cycle after
//                a qualified input; outputs hold while no new input arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH:0]   total
);

    // Carry chain: index 0 is the external carry-in, index WIDTH the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             c_out_q;
    logic             c_out_d;

    assign w_carry[0] = c_in;

    // One cell per bit; each cell consumes the carry of the cell below it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (w_carry[gi]),
                .sum  (w_sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Next-state: capture a fresh result only on qualified inputs, else hold.
    always_comb begin
        out_valid_d = in_valid;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        if (in_valid) begin
            sum_d   = w_sum;
            c_out_d = w_carry[WIDTH];
        end
    end

    // Output register stage; reset wins over any operands presented with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign total     = {c_out_q, sum_q};

endmodule : full_adder_4bit
`default_nettype wire

// File: tb/tb_full_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_4bit
//  Description : Directed self-checking bench for full_adder_4bit (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         c_out;
    logic [W:0]   total;

    int tests_run;
    int tests_failed;

    full_adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .sum       (sum),
        .c_out     (c_out),
        .total     (total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge, then settle past the rising edge.
    task automatic drive(input logic r, input logic v, input int aa, input int bb, input int cc);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = W'(aa);
        b        = W'(bb);
        c_in     = cc[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ov, input int tot);
        chk({tag, "/out_valid"}, int'(out_valid), ov);
        chk({tag, "/total"},     int'(total),     tot);
        chk({tag, "/sum"},       int'(sum),       tot % 16);
        chk({tag, "/c_out"},     int'(c_out),     tot / 16);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;

        // Reset state, then idle cycle with garbage operands must not disturb it.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk_all("reset", 0, 0);
        drive(0, 0, 5, 6, 1);
        chk_all("idle_after_reset", 0, 0);

        // Maximum operands with carry-in.
        drive(0, 1, 15, 15, 1);
        chk_all("max_15_15_1", 1, 31);

        // Carry ripples through every bit, then an all-zero result.
        drive(0, 1, 7, 8, 1);
        chk_all("ripple_7_8_1", 1, 16);
        drive(0, 1, 0, 0, 0);
        chk_all("zero_0_0_0", 1, 0);

        // Exhaustive back-to-back sweep at full throughput.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    drive(0, 1, ia, ib, ic);
                    chk_all($sformatf("exh_%0d_%0d_%0d", ia, ib, ic), 1, ia + ib + ic);
                end
            end
        end

        // Single valid pulse: result holds while invalid operands are ignored.
        drive(0, 1, 3, 4, 0);
        chk_all("pulse_1", 1, 7);
        drive(0, 0, 12, 13, 1);
        chk_all("pulse_0a", 0, 7);
        drive(0, 0, 9, 2, 0);
        chk_all("pulse_0b", 0, 7);

        // Reset collides with a valid input: operands discarded, outputs cleared.
        drive(0, 1, 9, 9, 1);
        chk_all("preload_9_9_1", 1, 19);
        drive(1, 1, 9, 9, 0);
        chk_all("rst_with_valid", 0, 0);
        drive(0, 0, 9, 9, 0);
        chk_all("idle_after_rst", 0, 0);
        drive(0, 1, 2, 3, 1);
        chk_all("first_after_rst", 1, 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_full_adder_4bit
`default_nettype wire
